// File: rtl/irrigation_scheduler_if.sv
// Request/sensor inputs and actuator/status outputs of the irrigation scheduler.
// The scheduler takes the slave side; whoever drives the requests and sensors takes the master side.
interface irrigation_scheduler_if;
  logic       splinker_request;
  logic       dripper_request;
  logic       alarm;
  logic       low_water_level;
  logic       high_water_level;
  logic       water_supply_valvule;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic [1:0] fault_code;
  logic       busy;

  modport master (
    output splinker_request, dripper_request, alarm, low_water_level, high_water_level,
    input  water_supply_valvule, splinker_bomb, dripper_valvule, fault_code, busy
  );

  modport slave (
    input  splinker_request, dripper_request, alarm, low_water_level, high_water_level,
    output water_supply_valvule, splinker_bomb, dripper_valvule, fault_code, busy
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// Arbitrates the tank's single water path between the refill valve, the sprinkler pump and
// the dripper valve, enforcing on-time limits, cooldown, round-robin fairness and fault latching.
module irrigation_scheduler #(
  parameter int unsigned MIN_ON_CYCLES         = 4,
  parameter int unsigned MAX_ON_CYCLES         = 16,
  parameter int unsigned COOLDOWN_CYCLES       = 3,
  parameter int unsigned REFILL_TIMEOUT_CYCLES = 20,
  parameter int unsigned FAULT_CLEAR_CYCLES    = 5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  irrigation_scheduler_if.slave  bus
);

  localparam int unsigned MAX_AB = (MAX_ON_CYCLES > COOLDOWN_CYCLES) ? MAX_ON_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned MAX_CD = (REFILL_TIMEOUT_CYCLES > FAULT_CLEAR_CYCLES) ?
                                   REFILL_TIMEOUT_CYCLES : FAULT_CLEAR_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_ON_CYCLES);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_ON_CYCLES);
  localparam logic [CW-1:0] COOL_C  = CW'(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] REF_C   = CW'(REFILL_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CLR_C   = CW'(FAULT_CLEAR_CYCLES);

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ALARM   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REFILL   = 3'd1,
    ST_SPRINKLE = 3'd2,
    ST_DRIP     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  typedef enum logic {
    SRV_DRIP = 1'b0,
    SRV_SPR  = 1'b1
  } served_e;

  logic [4:0]    sync1_q, sync2_q;
  logic          spr_s, drp_s, alarm_s, low_s, high_s;
  state_e        state_q, state_d;
  served_e       last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    fault_q, fault_d;
  logic          valve_q, bomb_q, drip_q, busy_q;

  assign {spr_s, drp_s, alarm_s, low_s, high_s} = sync2_q;

  // Two-flop synchronisers for every asynchronous input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 5'b00000;
      sync2_q <= 5'b00000;
    end else begin
      sync1_q <= {bus.splinker_request, bus.dripper_request, bus.alarm,
                  bus.low_water_level, bus.high_water_level};
      sync2_q <= sync1_q;
    end
  end

  // cnt_inc is the number of cycles spent in the current state including this one.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, fault and fairness decode.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    last_d  = last_q;
    if (alarm_s && (fault_q != FC_TIMEOUT)) begin
      state_d = ST_FAULT;
      fault_d = FC_ALARM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!low_s) begin
            state_d = ST_REFILL;
          end else if (spr_s && (!drp_s || (last_q == SRV_DRIP))) begin
            state_d = ST_SPRINKLE;
            last_d  = SRV_SPR;
          end else if (drp_s) begin
            state_d = ST_DRIP;
            last_d  = SRV_DRIP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REFILL: begin
          if (high_s) begin
            state_d = ST_IDLE;
          end else if (cnt_inc == REF_C) begin
            state_d = ST_FAULT;
            fault_d = FC_TIMEOUT;
          end else begin
            state_d = ST_REFILL;
          end
        end
        ST_SPRINKLE, ST_DRIP: begin
          // Low water cuts the grant short even inside the minimum on-time.
          if (!low_s || (cnt_inc == MAX_C) ||
              ((cnt_inc >= MIN_C) && !((state_q == ST_SPRINKLE) ? spr_s : drp_s))) begin
            state_d = ST_COOLDOWN;
          end else begin
            state_d = state_q;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_inc == COOL_C) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOLDOWN;
          end
        end
        ST_FAULT: begin
          if ((fault_q == FC_ALARM) && (cnt_inc == CLR_C)) begin
            state_d = ST_IDLE;
            fault_d = FC_NONE;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // An alarm seen while already in FAULT restarts the clean-run count.
    if ((state_d != state_q) || ((state_q == ST_FAULT) && alarm_s)) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // State register plus actuator outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= SRV_DRIP;
      cnt_q   <= {CW{1'b0}};
      fault_q <= FC_NONE;
      valve_q <= 1'b0;
      bomb_q  <= 1'b0;
      drip_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      valve_q <= (state_d == ST_REFILL);
      bomb_q  <= (state_d == ST_SPRINKLE);
      drip_q  <= (state_d == ST_DRIP);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.water_supply_valvule = valve_q;
  assign bus.splinker_bomb        = bomb_q;
  assign bus.dripper_valvule      = drip_q;
  assign bus.fault_code           = fault_q;
  assign bus.busy                 = busy_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler (parameters 4/16/3/20/5): vector table plus
// hand-written multi-cycle sequences, all compared through an expected-output queue.
module tb_irrigation_scheduler;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  irrigation_scheduler_if bus();

  irrigation_scheduler #(
    .MIN_ON_CYCLES(4), .MAX_ON_CYCLES(16), .COOLDOWN_CYCLES(3),
    .REFILL_TIMEOUT_CYCLES(20), .FAULT_CLEAR_CYCLES(5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs packed as {spr, drp, alarm, low, high}.
  localparam logic [4:0] IN_FULL  = 5'b00011;
  localparam logic [4:0] IN_SPR   = 5'b10011;
  localparam logic [4:0] IN_DRP   = 5'b01011;
  localparam logic [4:0] IN_BOTH  = 5'b11011;
  // Outputs packed as {valve, bomb, dripper, fault_code[1:0], busy}.
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_SPR  = 6'b010001;
  localparam logic [5:0] O_DRP  = 6'b001001;
  localparam logic [5:0] O_REF  = 6'b100001;
  localparam logic [5:0] O_COOL = 6'b000001;
  localparam logic [5:0] O_FAL  = 6'b000011;
  localparam logic [5:0] O_FTO  = 6'b000101;

  typedef struct {
    logic [4:0] in;
    logic [5:0] exp;
  } vec_t;

  logic [5:0] exp_q[$];

  function automatic logic [5:0] outs();
    return {bus.water_supply_valvule, bus.splinker_bomb, bus.dripper_valvule,
            bus.fault_code, bus.busy};
  endfunction

  task automatic drive(input logic [4:0] in);
    {bus.splinker_request, bus.dripper_request, bus.alarm,
     bus.low_water_level, bus.high_water_level} = in;
  endtask

  task automatic chk(input logic [5:0] e, input string tag);
    logic [5:0] a;
    a = outs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, a, e);
    end
  endtask

  // Called at a negedge: drive, queue the expectation, compare after the next rising edge.
  task automatic step(input logic [4:0] in, input logic [5:0] e, input string tag, input int idx);
    logic [5:0] exp_v;
    drive(in);
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    exp_v = exp_q.pop_front();
    chk(exp_v, $sformatf("%s[%0d]", tag, idx));
  endtask

  task automatic settle(input int n);
    drive(IN_FULL);
    repeat (n) @(negedge clock);
  endtask

  // At most one actuator may ever be energised.
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if ((int'(bus.water_supply_valvule) + int'(bus.splinker_bomb) + int'(bus.dripper_valvule)) > 1) begin
        errors++;
        $display("FAIL exclusive: got %b%b%b expected at most one high",
                 bus.water_supply_valvule, bus.splinker_bomb, bus.dripper_valvule);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[11];
    logic [5:0] e;
    int         p;

    // Single-cycle sprinkler pulse: 2 sync cycles, 4 on, 3 cooldown, then idle.
    tbl[0]  = '{IN_SPR,  O_IDLE};
    tbl[1]  = '{IN_FULL, O_IDLE};
    tbl[2]  = '{IN_FULL, O_SPR};
    tbl[3]  = '{IN_FULL, O_SPR};
    tbl[4]  = '{IN_FULL, O_SPR};
    tbl[5]  = '{IN_FULL, O_SPR};
    tbl[6]  = '{IN_FULL, O_COOL};
    tbl[7]  = '{IN_FULL, O_COOL};
    tbl[8]  = '{IN_FULL, O_COOL};
    tbl[9]  = '{IN_FULL, O_IDLE};
    tbl[10] = '{IN_FULL, O_IDLE};

    reset_n = 1'b0;
    drive(IN_FULL);
    repeat (2) @(negedge clock);
    chk(O_IDLE, "reset");
    reset_n = 1'b1;
    settle(8);
    chk(O_IDLE, "startup_idle");

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].in, tbl[i].exp, "pulse", i);
    end

    // Async reset in the middle of a sprinkler grant.
    drive(IN_SPR);
    for (int i = 0; i < 10 && !bus.splinker_bomb; i++) @(negedge clock);
    chk(O_SPR, "mid_spr_on");
    drive(IN_FULL);
    #2 reset_n = 1'b0;
    #1 chk(O_IDLE, "async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    settle(8);

    // Both requests held: sprinkler wins the first tie, then strict alternation.
    for (int k = 0; k < 44; k++) begin
      p = (k - 2) % 20;
      if (k < 2)       e = O_IDLE;
      else if (p < 16) e = ((((k - 2) / 20) % 2) == 0) ? O_SPR : O_DRP;
      else if (p < 19) e = O_COOL;
      else             e = O_IDLE;
      step(IN_BOTH, e, "both", k);
    end
    settle(30);
    chk(O_IDLE, "both_done");

    // Refill with a pending sprinkler request; high sensor arrives at cycle 10.
    for (int k = 0; k < 15; k++) begin
      if (k < 2)       e = O_IDLE;
      else if (k < 12) e = O_REF;
      else if (k < 13) e = O_IDLE;
      else             e = O_SPR;
      step({(k < 12) ? 1'b1 : 1'b0, 1'b0, 1'b0, (k >= 5) ? 1'b1 : 1'b0, (k >= 10) ? 1'b1 : 1'b0},
           e, "refill", k);
    end
    settle(20);
    chk(O_IDLE, "refill_done");

    // Refill that never fills: 20 valve cycles, then sticky timeout fault.
    for (int k = 0; k < 23; k++) begin
      if (k < 2)       e = O_IDLE;
      else if (k < 22) e = O_REF;
      else             e = O_FTO;
      step(5'b00000, e, "timeout", k);
    end
    for (int k = 0; k < 10; k++) begin
      step((k == 4) ? 5'b11111 : IN_BOTH, O_FTO, "timeout_hold", k);
    end
    #2 reset_n = 1'b0;
    #1 chk(O_IDLE, "timeout_reset");
    @(negedge clock);
    reset_n = 1'b1;
    settle(8);

    // Alarm during DRIP, a 3-cycle clean run that is too short, then a 5-cycle clean run.
    for (int k = 0; k < 18; k++) begin
      if (k < 2)       e = O_IDLE;
      else if (k < 6)  e = O_DRP;
      else if (k < 17) e = O_FAL;
      else             e = O_IDLE;
      step({1'b0, (k < 6) ? 1'b1 : 1'b0,
            ((k >= 4 && k <= 6) || k == 10) ? 1'b1 : 1'b0, 1'b1, 1'b1},
           e, "alarm", k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Clocked sequencer that owns the tank's single water path and grants it to at most one consumer at a time: refill valve, sprinkler pump or dripper valve. It sits between the combinational sprinkler/dripper decision logic and the physical actuators. It adds minimum/maximum on-times, a cooldown gap, round-robin fairness between sprinkler and dripper, and tank-refill priority. It latches faults and de-energises every actuator while a water-sensor fault is present.

## Interface
- MIN_ON_CYCLES, 4: minimum cycles an irrigator stays on once granted (≥1, ≤MAX_ON_CYCLES)
- MAX_ON_CYCLES, 16: maximum cycles per irrigation grant
- COOLDOWN_CYCLES, 3: all-off gap after every irrigation grant (≥1)
- REFILL_TIMEOUT_CYCLES, 20: maximum cycles in REFILL before declaring a supply fault
- FAULT_CLEAR_CYCLES, 5: consecutive alarm-free cycles required to leave a sensor fault
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- splinker_request  in  1  sprinkler decision from the splinker logic (async)
- dripper_request  in  1  dripper decision from the dripper logic (async)
- alarm  in  1  water-level sensor inconsistency (async)
- low_water_level  in  1  1 = water at or above the low sensor (async)
- high_water_level  in  1  1 = water at or above the high sensor (async)
- water_supply_valvule  out  1  refill valve, registered
- splinker_bomb  out  1  sprinkler pump, registered
- dripper_valvule  out  1  dripper valve, registered
- fault_code  out  2  00 none, 01 sensor alarm, 10 refill timeout (sticky), registered
- busy  out  1  1 when the state is not IDLE, registered

## Operation
- All five async inputs pass through 2-flop synchronisers. The `_s` suffix below denotes synchronised values.
- States: IDLE, REFILL, SPRINKLE, DRIP, COOLDOWN, FAULT. One counter, `cnt`, is sized $clog2 of the largest parameter plus 1, saturating, and is cleared on every state entry.
- Highest priority, from any state: if alarm_s=1, go to FAULT with fault_code=01, unless fault_code is already 10.
- IDLE:
  - low_water_level_s=0 → REFILL.
  - Otherwise, if exactly one request_s is high, grant it: SPRINKLE or DRIP.
  - If both are high, grant the one not served last. `last_served` resets to dripper, so the sprinkler wins the first tie.
  - `last_served` updates on entry to SPRINKLE/DRIP.
- REFILL: water_supply_valvule=1.
  - high_water_level_s=1 → IDLE.
  - cnt reaches REFILL_TIMEOUT_CYCLES → FAULT with fault_code=10.
- SPRINKLE / DRIP: only the matching actuator is 1. Go to COOLDOWN when any of these holds:
  - low_water_level_s=0, which overrides the minimum on-time.
  - cnt ≥ MIN_ON_CYCLES and the own request_s=0.
  - cnt reaches MAX_ON_CYCLES.
- COOLDOWN: all actuators 0; after COOLDOWN_CYCLES → IDLE. Pending requests are re-arbitrated in IDLE.
- FAULT: all actuators 0.
  - fault_code=01: cnt counts consecutive alarm_s=0 cycles and restarts on any alarm_s=1. Reaching FAULT_CLEAR_CYCLES → IDLE with fault_code=00.
  - fault_code=10: the state is held until reset_n.
- Invariant: at most one of the three actuator outputs is high in any cycle.

## Timing
- Reset (async assert, released synchronously by the flops' next edge) sets:
  - all actuators=0, fault_code=00, busy=0
  - state=IDLE, cnt=0, last_served=dripper
  - synchroniser flops=0
- Input-to-output latency is 3 rising edges: ff1, ff2, then the state register. Actuator outputs are decoded from the next state and registered, so they change on the same edge as the state.
- Time limits are measured in on-cycles:
  - An irrigator output is high for ≥MIN_ON_CYCLES and ≤MAX_ON_CYCLES cycles, except on an early exit for low water or an alarm.
  - The refill valve is high for at most REFILL_TIMEOUT_CYCLES cycles.
- Handover: there is no back-to-back irrigation. Between two irrigator grants there are ≥COOLDOWN_CYCLES cycles with all actuators off plus 1 IDLE cycle.
- Alarm mid-operation: every actuator drops on the edge that registers alarm_s, in the same cycle as the FAULT entry.
- Reset mid-operation: outputs drop immediately and asynchronously.

## Test plan
- Parameters 4/16/3/20/5. splinker_request pulsed high for 1 cycle, tank full → splinker_bomb high exactly 4 cycles, then 3 off-cycles in COOLDOWN, then IDLE with busy=0.
- Both requests held high, tank full → the grant order is SPRINKLE(16), COOLDOWN(3), IDLE(1), DRIP(16), COOLDOWN, IDLE, SPRINKLE. splinker_bomb and dripper_valvule are never high together.
- low_water_level=0 with a request pending → water_supply_valvule=1. Then high_water_level=1 at cycle 10 → valve drops 3 edges later, and the pending request is granted afterwards.
- Refill with high_water_level never asserting → valve high 20 cycles then 0, fault_code=10. The state stays FAULT despite requests until reset_n pulses low.
- alarm asserted during DRIP → dripper_valvule=0 at the 3rd edge, fault_code=01. alarm drops for 3 cycles, re-asserts, then drops for 5 cycles → IDLE and fault_code=00 only after the 5-cycle clean run.
- reset_n asserted low mid-SPRINKLE → splinker_bomb=0 asynchronously before the next edge. After release, the first tie goes to the sprinkler.
